// File: rtl/dispatch_pkg.sv
// Shared opcodes, NOP encodings and the scalar/vector split rule used by the dispatch stage.
package dispatch_pkg;

  localparam logic [2:0]  OPC_VLOAD   = 3'b100;
  localparam logic [2:0]  OPC_VSTORE  = 3'b101;
  localparam logic [11:0] ADDI_PREFIX = 12'h200;
  localparam logic [31:0] SNOP        = 32'h2000_0000;
  localparam logic [31:0] VNOP        = 32'h1C00_0000;

  typedef struct packed {
    logic [31:0] s_inst;
    logic [31:0] v_inst;
    logic        need_s;
    logic        need_v;
  } split_t;

  // Vector memory ops need a scalar address-generation partner; other vector ops do not.
  function automatic split_t classify(input logic mode, input logic [31:0] inst);
    split_t r;
    r.s_inst = inst;
    r.v_inst = VNOP;
    r.need_s = 1'b1;
    r.need_v = 1'b0;
    if (mode) begin
      r.v_inst = inst;
      r.need_v = 1'b1;
      if (inst[31:29] == OPC_VLOAD || inst[31:29] == OPC_VSTORE) begin
        r.s_inst = {ADDI_PREFIX, inst[19:0]};
      end else begin
        r.s_inst = SNOP;
        r.need_s = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// First-word-fall-through issue queue; push visible at head one cycle later, pop advances same edge.
// Pushes are refused on full regardless of a same-cycle pop; flush and reset clear it synchronously.
module dispatch_fifo #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [DATA_W-1:0] EMPTY_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            push_dat,
  output logic                         full,
  output logic                         empty,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full && !flush && !rst;
  assign pop_ok  = pop && !empty && !flush && !rst;
  assign head    = empty ? EMPTY_VAL : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/inst_dispatch_split.sv
// Splits each fetched instruction into scalar and vector halves and queues them for the two decoders.
// in_ready drops when a required queue is full (both queues when PAIRED), and during flush or reset.
module inst_dispatch_split
  import dispatch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PAIRED = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [DATA_W-1:0]          in_inst,
  output logic                       s_valid,
  input  logic                       s_ready,
  output logic [DATA_W-1:0]          s_inst,
  output logic                       v_valid,
  input  logic                       v_ready,
  output logic [DATA_W-1:0]          v_inst,
  output logic [$clog2(DEPTH+1)-1:0] s_count,
  output logic [$clog2(DEPTH+1)-1:0] v_count
);

  split_t cls;
  logic   s_full, v_full;
  logic   s_empty, v_empty;
  logic   room, accept;
  logic   s_push, v_push;

  assign cls = classify(in_mode, in_inst);

  // Decoupled mode only needs room on the sides that carry real work.
  assign room = (PAIRED != 0) ? (!s_full && !v_full)
                              : ((!cls.need_s || !s_full) && (!cls.need_v || !v_full));

  assign in_ready = room && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign s_push   = accept && ((PAIRED != 0) || cls.need_s);
  assign v_push   = accept && ((PAIRED != 0) || cls.need_v);
  assign s_valid  = !s_empty;
  assign v_valid  = !v_empty;

  dispatch_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .EMPTY_VAL(SNOP)
  ) u_s_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (s_push),
    .pop     (s_ready && s_valid),
    .push_dat(cls.s_inst),
    .full    (s_full),
    .empty   (s_empty),
    .head    (s_inst),
    .count   (s_count)
  );

  dispatch_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .EMPTY_VAL(VNOP)
  ) u_v_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (v_push),
    .pop     (v_ready && v_valid),
    .push_dat(cls.v_inst),
    .full    (v_full),
    .empty   (v_empty),
    .head    (v_inst),
    .count   (v_count)
  );

endmodule

// File: doc/inst_dispatch_split.md
Name: inst_dispatch_split

Overview:
- Sequential successor to the scalar/vector instruction splitter.
- Accepts one fetched instruction per cycle and classifies it by execution mode and opcode.
- Pushes the scalar-side and vector-side instructions into two buffered issue queues with valid/ready handshakes.
- Sits between fetch and the scalar/vector decode stages; supports lockstep (paired) or decoupled issue.

Parameters:
- DATA_W, 32: instruction width.
- DEPTH, 4: entries per issue queue; must be a power of two, at least 2.
- PAIRED, 1: 1 = lockstep, both queues always pushed together; 0 = decoupled, NOP-only sides are not pushed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of both queues
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_mode  in  1  0 = scalar stream, 1 = vector stream
- in_inst  in  DATA_W  fetched instruction
- s_valid  out  1  scalar queue non-empty
- s_ready  in  1  scalar consumer pops head
- s_inst  out  DATA_W  scalar queue head
- v_valid  out  1  vector queue non-empty
- v_ready  in  1  vector consumer pops head
- v_inst  out  DATA_W  vector queue head
- s_count  out  $clog2(DEPTH+1)  scalar occupancy
- v_count  out  $clog2(DEPTH+1)  vector occupancy

Behaviour:
Reset and head values:
- One clock; reset is synchronous and active-high (clk, rst). On rst both queues are empty.
- Reset values: s_valid=0, v_valid=0, s_count=0, v_count=0, in_ready=0 during the reset cycle.
- When a queue is empty its head output drives its NOP: s_inst=SNOP (32'h2000_0000), v_inst=VNOP (32'h1C00_0000).

Classification (combinational on in_mode, in_inst), opc = in_inst[31:29]:
- mode 0: scalar side = in_inst; vector side = VNOP (NOP-only).
- mode 1, opc 3'b100 or 3'b101 (vector memory op): scalar side = {ADDI_PREFIX 12'h200, in_inst[19:0]}; vector side = in_inst.
- mode 1, other opc: scalar side = SNOP (NOP-only); vector side = in_inst.

Ready rule:
- PAIRED=1: in_ready = !s_full && !v_full && !flush && !rst. Every accept pushes both queues.
- PAIRED=0: in_ready = every needed queue not full, and !flush, and !rst. Only the needed sides are pushed.
- in_ready may depend on in_mode/in_inst; upstream holds in_mode/in_inst stable while in_valid && !in_ready.
- Full queue: in_ready is computed from occupancy only. No same-cycle pass-through when full, even if a pop occurs.

Queues:
- First-word-fall-through. A push is visible at the head one cycle later.
- A pop (valid && ready) advances the head the same edge.
- Simultaneous push and pop on a non-empty queue: count unchanged.
- Pointers wrap modulo DEPTH.

flush:
- Takes priority over push and pop. Next cycle both queues are empty and counts are 0.
- Any in_valid during the flush cycle is not accepted.
- rst takes priority over flush.
- rst asserted mid-stream discards all contents identically.

Decomposition:
- Package dispatch_pkg holds:
  - OPC_VLOAD = 3'b100, OPC_VSTORE = 3'b101
  - ADDI_PREFIX = 12'h200
  - SNOP, VNOP
  - a classify function returning {s_inst, v_inst, need_s, need_v}
- Sub-module: dispatch_fifo (parametrised DATA_W, DEPTH, EMPTY_VAL).
  - FWFT, synchronous reset and flush, count output.
  - Instantiated twice.

Test Plan:
- PAIRED=1, send mode0 32'h0123_4567 with both readies high:
  - next cycle s_inst=32'h0123_4567, v_inst=VNOP, both valid.
  - counts return to 0 after the pop.
- PAIRED=1, mode1 32'h8005_0010 (opc 100):
  - s_inst=32'h2005_0010, v_inst=32'h8005_0010.
  - mode1 32'hC000_0001 gives s_inst=SNOP.
- PAIRED=1, v_ready=0, push 4 instructions: v_count=4, in_ready=0.
  - Raise v_ready, s_ready high: one pop per cycle, in_ready returns the cycle after the first pop.
- PAIRED=0, s_ready=0, push 6 mode1 non-memory instructions: v queue gets all 6, s_count stays 0.
  - Then one mode1 opc-101 instruction stalls (in_ready=0) only while the s queue is full.
- Fill both queues to 3, assert flush with in_valid high:
  - next cycle counts=0, valids=0, heads=NOPs, and the instruction is not accepted.
- Wrap-around: stream 3*DEPTH mixed instructions with random readies.
  - Output order per queue matches the reference model; assert rst mid-stream and confirm empty queues the following cycle.
